sprite_compositor: RTL and testbench

- Parametrised N-channel sprite compositor; generalises the single-sprite pipeline to NSPR hardware sprites.
- Holds per-sprite position/enable registers, double-buffered and swapped at frame start, and drives them to NSPR sprite instances.
- Each cycle, merges the sprites' colour-index streams by fixed priority with transparency and outputs one registered index to the CLUT.
- Optionally reports per-frame sprite collisions.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_prio_enc.sv | 28 ++
 rtl/sprite_compositor.sv | 124 ++++++++++++
 tb/tb_sprite_compositor.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, defaults and helpers for the multi-sprite compositor.
package sprite_pkg;

  localparam int SPR_CORDW = 16;
  localparam int SPR_NSPR  = 4;
  localparam int SPR_CIDXW = 4;
  // Widest colour index the transparency helper accepts.
  localparam int CIDX_MAX  = 16;
  // Extra sprite-to-CLUT delay added by the compositor register stage.
  localparam int COMP_LAT  = 1;

  typedef logic signed [SPR_CORDW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   en;
  } spr_reg_t;

  function automatic logic cidx_is_trans(input logic [CIDX_MAX-1:0] cidx,
                                         input logic [CIDX_MAX-1:0] trans);
    return cidx == trans;
  endfunction

endpackage

// File: rtl/sprite_prio_enc.sv
// Lowest-index-first priority encoder; also flags when two or more inputs are set.
module sprite_prio_enc #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [SELW-1:0] idx,
  output logic            multi
);

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          any = 1'b1;
          idx = SELW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: double-buffered sprite registers, priority merge, collisions.
// Define SPRITE_COLLIDE_EN to build the per-frame collision accumulator; otherwise coll is 0.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int                CORDW      = SPR_CORDW,
  parameter int                NSPR       = SPR_NSPR,
  parameter int                CIDXW      = SPR_CIDXW,
  parameter logic [CIDXW-1:0]  TRANS_INDX = 'hF,
  parameter int                SELW       = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  input  logic                    reg_we,
  input  logic [SELW-1:0]         reg_sel,
  input  logic signed [CORDW-1:0] reg_x,
  input  logic signed [CORDW-1:0] reg_y,
  input  logic                    reg_en,
  output logic [NSPR*CORDW-1:0]   sprx,
  output logic [NSPR*CORDW-1:0]   spry,
  input  logic [NSPR-1:0]         spr_drawing,
  input  logic [NSPR*CIDXW-1:0]   spr_pix,
  output logic                    pix_valid,
  output logic [CIDXW-1:0]        pix_indx,
  output logic [SELW-1:0]         pix_sel,
  output logic [NSPR-1:0]         coll
);

  typedef struct packed {
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    en;
  } slot_t;

  slot_t shadow [NSPR];
  slot_t active [NSPR];

  logic            sel_ok;
  logic [NSPR-1:0] opaque;
  logic            any;
  logic [SELW-1:0] win_idx;
  logic            multi;
  logic [CIDXW-1:0] win_pix;

  assign sel_ok = (32'(reg_sel) < NSPR);

  // Active copy takes the pre-write shadow, so a same-cycle write lands next frame.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < NSPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame) begin
        for (int i = 0; i < NSPR; i++) active[i] <= shadow[i];
      end
      if (reg_we && sel_ok) shadow[reg_sel] <= '{x: reg_x, y: reg_y, en: reg_en};
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_out
    assign sprx[g*CORDW +: CORDW] = active[g].x;
    assign spry[g*CORDW +: CORDW] = active[g].y;
  end

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NSPR; i++) begin
      opaque[i] = spr_drawing[i] && active[i].en &&
                  !cidx_is_trans(CIDX_MAX'(spr_pix[i*CIDXW +: CIDXW]), CIDX_MAX'(TRANS_INDX));
    end
  end

  sprite_prio_enc #(
    .N    (NSPR),
    .SELW (SELW)
  ) u_prio (
    .req   (opaque),
    .any   (any),
    .idx   (win_idx),
    .multi (multi)
  );

  assign win_pix = spr_pix[int'(win_idx)*CIDXW +: CIDXW];

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pix_valid <= 1'b0;
      pix_indx  <= '0;
      pix_sel   <= '0;
    end else begin
      pix_valid <= any;
      pix_indx  <= any ? win_pix : '0;
      pix_sel   <= any ? win_idx : '0;
    end
  end

`ifdef SPRITE_COLLIDE_EN
  logic [NSPR-1:0] acc;
  logic [NSPR-1:0] contrib;

  assign contrib = multi ? opaque : '0;

  // The frame cycle's own overlap seeds the new frame instead of being dropped.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      acc  <= '0;
      coll <= '0;
    end else if (frame) begin
      coll <= acc;
      acc  <= contrib;
    end else begin
      acc  <= acc | contrib;
    end
  end
`else
  logic unused_multi;
  assign unused_multi = multi;
  assign coll = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: register swap, priority, transparency, collisions, reset.
module tb_sprite_compositor;

  localparam int CORDW = 16;
  localparam int NSPR  = 4;
  localparam int CIDXW = 4;
  localparam int SELW  = 2;
  localparam logic [CIDXW-1:0] TRANS = 4'hF;

  logic                  clk_pix = 1'b0;
  logic                  rst_pix_n = 1'b0;
  logic                  frame = 1'b0;
  logic                  reg_we = 1'b0;
  logic [SELW-1:0]       reg_sel = '0;
  logic [CORDW-1:0]      reg_x = '0;
  logic [CORDW-1:0]      reg_y = '0;
  logic                  reg_en = 1'b0;
  logic [NSPR*CORDW-1:0] sprx;
  logic [NSPR*CORDW-1:0] spry;
  logic [NSPR-1:0]       spr_drawing = '0;
  logic [NSPR*CIDXW-1:0] spr_pix = '0;
  logic                  pix_valid;
  logic [CIDXW-1:0]      pix_indx;
  logic [SELW-1:0]       pix_sel;
  logic [NSPR-1:0]       coll;

  sprite_compositor #(
    .CORDW      (CORDW),
    .NSPR       (NSPR),
    .CIDXW      (CIDXW),
    .TRANS_INDX (TRANS),
    .SELW       (SELW)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .frame       (frame),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .reg_x       (reg_x),
    .reg_y       (reg_y),
    .reg_en      (reg_en),
    .sprx        (sprx),
    .spry        (spry),
    .spr_drawing (spr_drawing),
    .spr_pix     (spr_pix),
    .pix_valid   (pix_valid),
    .pix_indx    (pix_indx),
    .pix_sel     (pix_sel),
    .coll        (coll)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic             valid;
    logic [CIDXW-1:0] indx;
    logic [SELW-1:0]  sel;
  } exp_t;

  exp_t exp_q[$];

  logic [CORDW-1:0] sh_x [NSPR];
  logic [CORDW-1:0] sh_y [NSPR];
  logic             sh_en [NSPR];
  logic [CORDW-1:0] act_x [NSPR];
  logic [CORDW-1:0] act_y [NSPR];
  logic             act_en [NSPR];
  logic [NSPR-1:0]  m_acc;
  logic [NSPR-1:0]  m_coll;

  int checks = 0;
  int passed = 0;

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      sh_x[i] = '0; sh_y[i] = '0; sh_en[i] = 1'b0;
      act_x[i] = '0; act_y[i] = '0; act_en[i] = 1'b0;
    end
    m_acc  = '0;
    m_coll = '0;
    exp_q.delete();
  endtask

  function automatic logic [NSPR-1:0] model_opaque();
    logic [NSPR-1:0] o;
    for (int i = 0; i < NSPR; i++)
      o[i] = spr_drawing[i] && act_en[i] && (spr_pix[i*CIDXW +: CIDXW] != TRANS);
    return o;
  endfunction

  function automatic logic [NSPR-1:0] exp_coll();
`ifdef SPRITE_COLLIDE_EN
    return m_coll;
`else
    return '0;
`endif
  endfunction

  // One clock: the model updates from whatever is driven when the edge arrives.
  task automatic tick();
    logic [NSPR-1:0] o;
    logic [NSPR-1:0] contrib;
    o = model_opaque();
    contrib = ($countones(o) >= 2) ? o : '0;
    @(posedge clk_pix);
    if (frame) begin
      for (int i = 0; i < NSPR; i++) begin
        act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_en[i] = sh_en[i];
      end
      m_coll = m_acc;
      m_acc  = contrib;
    end else begin
      m_acc = m_acc | contrib;
    end
    if (reg_we && (int'(reg_sel) < NSPR)) begin
      sh_x[reg_sel] = reg_x; sh_y[reg_sel] = reg_y; sh_en[reg_sel] = reg_en;
    end
    #1;
  endtask

  task automatic write_reg(input int sel, input int x, input int y, input logic en,
                           input logic with_frame);
    reg_we = 1'b1; reg_sel = SELW'(sel); reg_x = CORDW'(x); reg_y = CORDW'(y);
    reg_en = en; frame = with_frame;
    tick();
    reg_we = 1'b0; frame = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic drive_pix(input logic [NSPR-1:0] d, input logic [NSPR*CIDXW-1:0] p);
    exp_t e;
    logic [NSPR-1:0] o;
    spr_drawing = d;
    spr_pix = p;
    o = model_opaque();
    e.valid = |o; e.indx = '0; e.sel = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (o[i]) begin
        e.indx = p[i*CIDXW +: CIDXW];
        e.sel  = SELW'(i);
      end
    end
    exp_q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    spr_drawing = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_pix);
    #1;
    checks++;
    if ({sprx, spry} !== '0) $display("[TB] FAIL reset_xy: got %h/%h want 0", sprx, spry);
    else passed++;
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== '0)
      $display("[TB] FAIL reset_pix: got v=%0b i=%0h s=%0d want 0", pix_valid, pix_indx, pix_sel);
    else passed++;
    checks++;
    if (coll !== '0) $display("[TB] FAIL reset_coll: got %b want 0", coll);
    else passed++;
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
  endtask

  task automatic test_swap();
    write_reg(2, 32, 16, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (sprx[2*CORDW +: CORDW] !== act_x[2] || act_x[2] !== 16'd0)
      $display("[TB] FAIL swap_hold: got x=%0d want %0d", sprx[2*CORDW +: CORDW], act_x[2]);
    else passed++;
    pulse_frame();
    checks++;
    if (sprx[2*CORDW +: CORDW] !== act_x[2] || spry[2*CORDW +: CORDW] !== act_y[2])
      $display("[TB] FAIL swap_load: got %0d,%0d want %0d,%0d",
               sprx[2*CORDW +: CORDW], spry[2*CORDW +: CORDW], act_x[2], act_y[2]);
    else passed++;
  endtask

  task automatic test_priority();
    exp_t e;
    write_reg(1, 10, 20, 1'b1, 1'b0);
    write_reg(3, 30, 40, 1'b1, 1'b0);
    pulse_frame();
    drive_pix(4'b1010, {4'h7, 4'h0, 4'h5, 4'h0});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
      $display("[TB] FAIL priority: got v=%0b i=%0h s=%0d want v=%0b i=%0h s=%0d",
               pix_valid, pix_indx, pix_sel, e.valid, e.indx, e.sel);
    else passed++;
    idle(1);
  endtask

  task automatic test_transparency();
    exp_t e;
    write_reg(0, 0, 0, 1'b1, 1'b1);
    pulse_frame();
    drive_pix(4'b0101, {4'h0, 4'h9, 4'h0, 4'hF});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
      $display("[TB] FAIL trans: got v=%0b i=%0h s=%0d want v=%0b i=%0h s=%0d",
               pix_valid, pix_indx, pix_sel, e.valid, e.indx, e.sel);
    else passed++;
    write_reg(2, 32, 16, 1'b0, 1'b0);
    pulse_frame();
    drive_pix(4'b0101, {4'h0, 4'h9, 4'h0, 4'hF});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
      $display("[TB] FAIL disabled: got v=%0b i=%0h s=%0d want v=%0b i=%0h s=%0d",
               pix_valid, pix_indx, pix_sel, e.valid, e.indx, e.sel);
    else passed++;
    idle(1);
  endtask

  task automatic test_write_frame();
    write_reg(0, 100, 5, 1'b1, 1'b1);
    checks++;
    if (sprx[0 +: CORDW] !== act_x[0] || act_x[0] === 16'd100)
      $display("[TB] FAIL wr_frame_old: got x0=%0d want %0d", sprx[0 +: CORDW], act_x[0]);
    else passed++;
    pulse_frame();
    checks++;
    if (sprx[0 +: CORDW] !== act_x[0])
      $display("[TB] FAIL wr_frame_new: got x0=%0d want %0d", sprx[0 +: CORDW], act_x[0]);
    else passed++;
  endtask

  task automatic test_collision();
    exp_t e;
    write_reg(1, 50, 60, 1'b1, 1'b0);
    pulse_frame();
    idle(1);
    pulse_frame();
    for (int k = 0; k < 3; k++) begin
      drive_pix(4'b0011, {4'h0, 4'h0, 4'h2, 4'h1});
      e = exp_q.pop_front();
      checks++;
      if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
        $display("[TB] FAIL coll_pix: got v=%0b i=%0h s=%0d want v=%0b i=%0h s=%0d",
                 pix_valid, pix_indx, pix_sel, e.valid, e.indx, e.sel);
      else passed++;
    end
    idle(2);
    pulse_frame();
    checks++;
    if (coll !== exp_coll()) $display("[TB] FAIL coll_hit: got %b want %b", coll, exp_coll());
    else passed++;
    idle(3);
    checks++;
    if (coll !== exp_coll()) $display("[TB] FAIL coll_hold: got %b want %b", coll, exp_coll());
    else passed++;
    pulse_frame();
    checks++;
    if (coll !== exp_coll()) $display("[TB] FAIL coll_clear: got %b want %b", coll, exp_coll());
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int s = 0; s < NSPR; s++) write_reg(s, s * 8, s * 4, 1'b1, 1'b0);
    pulse_frame();
    for (int k = 0; k < 24; k++) begin
      drive_pix(NSPR'($urandom_range(0, 15)), (NSPR*CIDXW)'($urandom));
      e = exp_q.pop_front();
      checks++;
      if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
        $display("[TB] FAIL b2b_%0d: got v=%0b i=%0h s=%0d want v=%0b i=%0h s=%0d",
                 k, pix_valid, pix_indx, pix_sel, e.valid, e.indx, e.sel);
      else passed++;
    end
    idle(1);
    pulse_frame();
    checks++;
    if (coll !== exp_coll()) $display("[TB] FAIL b2b_coll: got %b want %b", coll, exp_coll());
    else passed++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive_pix(4'b0001, {4'h0, 4'h0, 4'h0, 4'h3});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel} || !e.valid)
      $display("[TB] FAIL pre_reset: got v=%0b i=%0h want v=%0b i=%0h",
               pix_valid, pix_indx, e.valid, e.indx);
    else passed++;
    #2 rst_pix_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pix_valid !== 1'b0 || coll !== '0 || sprx !== '0)
      $display("[TB] FAIL async_reset: got v=%0b coll=%b sprx=%h want 0", pix_valid, coll, sprx);
    else passed++;
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    write_reg(0, 7, 7, 1'b1, 1'b0);
    drive_pix(4'b0001, {4'h0, 4'h0, 4'h0, 4'h3});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
      $display("[TB] FAIL post_reset_dark: got v=%0b i=%0h want v=%0b i=%0h",
               pix_valid, pix_indx, e.valid, e.indx);
    else passed++;
    pulse_frame();
    drive_pix(4'b0001, {4'h0, 4'h0, 4'h0, 4'h3});
    e = exp_q.pop_front();
    checks++;
    if ({pix_valid, pix_indx, pix_sel} !== {e.valid, e.indx, e.sel})
      $display("[TB] FAIL post_reset_draw: got v=%0b i=%0h want v=%0b i=%0h",
               pix_valid, pix_indx, e.valid, e.indx);
    else passed++;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_swap();
    test_priority();
    test_transparency();
    test_write_frame();
    test_collision();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
